duty_step_sequencer: RTL
========================

// Module: duty_step_sequencer
// PURPOSE
// - Turns raw up/down push-buttons into clean, mutually exclusive step pulses for the PWM duty counter.
// - Per button: synchronise, debounce, then one stretched pulse; auto-repeat while held.
// - Arbitrates simultaneous presses. Sits between the board buttons and the counter's up_c/down_c inputs.
// PARAMETERS
// - CNT_W       8   width of the shared timer
// - DEB_CYCLES  16  cycles a sync'd button must stay stable before it is accepted (<= 2**CNT_W-1)
// - PULSE_W     4   cycles step_up/step_down stay high per step (>= 2)
// - REPEAT_DLY  64  cycles from end of first pulse to first auto-repeat pulse
// - REPEAT_PER  16  cycles from end of a pulse to the next auto-repeat pulse (>= PULSE_W)
// PORTS
// - clk        in   1  system clock, rising edge
// - reset_c    in   1  reset, asynchronous, active-high
// - up_btn     in   1  raw up button, async, active-high
// - down_btn   in   1  raw down button, async, active-high
// - hold_c     in   1  sync; 1 = suppress new steps (pulse in flight completes)
// - step_up    out  1  up step pulse, PULSE_W cycles high
// - step_down  out  1  down step pulse, PULSE_W cycles high
// - busy       out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
// - Reset: step_up=0, step_down=0, busy=0, FSM=IDLE, timer=0, sync flops=0. Outputs drop in the same instant as reset.
// - Input sync: 2-flop synchroniser per button -> u_s, d_s.
// - Debounce: per-button stable flag u_db/d_db.
//   - Changes only after the sync'd level has held DEB_CYCLES consecutive cycles.
//   - Any toggle restarts that button's count.
// - Timer: one shared CNT_W up-counter, cleared on every FSM state entry; saturates at all-ones, never wraps.
// - FSM states:
//   - IDLE
//     - u_db xor d_db, and hold_c=0 -> FIRE (dir latched: up if u_db).
//     - u_db and d_db both 1 -> LOCK.
//   - FIRE
//     - Latched output high for exactly PULSE_W cycles -> WAIT_DLY (first pulse) or WAIT_PER (repeats).
//   - WAIT_DLY / WAIT_PER
//     - Latched button released -> IDLE.
//     - Opposite button becomes 1 -> LOCK.
//     - Timer reaches REPEAT_DLY / REPEAT_PER with hold_c=0 -> FIRE.
//     - hold_c=1 at expiry: stay, re-evaluate each cycle.
//   - LOCK
//     - Both outputs 0; wait until u_db=0 and d_db=0 -> IDLE.
// - Output rules:
//   - step_up and step_down are never 1 simultaneously.
//   - Each pulse is followed by at least PULSE_W low cycles, so the downstream XOR-clocked counter sees one clean edge per step.
//   - Outputs are registered.
// - Latency: clean press -> step rises 2 (sync) + DEB_CYCLES + 1 cycles after the press edge.
// - Simultaneous debounce acceptance in the same cycle -> LOCK, no pulse.
// - hold_c rising mid-pulse: pulse completes full width; no further FIRE until hold_c=0.
// - Release during FIRE: pulse completes, then WAIT_* sees release -> IDLE.
// - Reset mid-pulse: output cleared immediately. After reset, a still-held button must re-debounce before firing.
// STRUCTURE
// - Package pwm_ctrl_pkg:
//   - FSM state enum {IDLE, FIRE, WAIT_DLY, WAIT_PER, LOCK}.
//   - Direction typedef {DIR_UP, DIR_DOWN}.
//   - Default timing constants.
// - Sub-module btn_debounce (sync + stable counter, param DEB_CYCLES), instantiated twice.
// - FSM, timer and output registers in the top module.
// TESTING (DEB_CYCLES=4, PULSE_W=2, REPEAT_DLY=8, REPEAT_PER=4)
// - Clean up press held 3 cycles then released -> no pulse.
// - Clean up press held 10 cycles -> one step_up, high 2 cycles starting at cycle 7; step_down stays 0.
// - Down held 40 cycles -> first pulse at cycle 7.
//   - Next rise 8 cycles after first pulse ends, then every 6 cycles (4 wait + 2 high).
//   - No pulse after release.
// - Bounce: up toggles every cycle for 6 cycles, then stays high -> exactly one pulse, 7 cycles after the last toggle.
// - Up and down pressed in the same cycle, 20 cycles -> no pulses, busy=1; after both released and debounced, busy=0.
// - Up held, down pressed mid-WAIT_DLY -> LOCK, no further pulses; release both -> IDLE.
// - reset_c asserted mid-pulse -> step_up=0 at once; press still held after reset -> new pulse at cycle 7 after deassert.
// - hold_c=1 during repeat -> no new pulses; hold_c=0 -> pulse on next cycle if the timer has expired.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing for the PWM duty-step front end.
// Holds the sequencer FSM states, the step direction, and the default timer widths and delays.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_DLY,
    WAIT_PER,
    LOCK
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_PULSE_W    = 4;
  localparam int DEF_REPEAT_DLY = 64;
  localparam int DEF_REPEAT_PER = 16;

endpackage

// File: rtl/btn_debounce.sv
// One push-button input: a two-flop synchroniser followed by a stable-level filter.
// The filtered level flips only after the synchronised level has differed from it for DEB_CYCLES cycles in a row.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_c,
  input  logic btn,
  output logic stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // A sample equal to the accepted level restarts the run, so any bounce costs a full window.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= btn;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/duty_step_sequencer.sv
// Converts the raw up/down buttons into mutually exclusive, fixed-width step pulses with auto-repeat.
// Both buttons are debounced, then one FSM with a shared saturating timer arbitrates and times the pulses.
module duty_step_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic reset_c,
  input  logic up_btn,
  input  logic down_btn,
  input  logic hold_c,
  output logic step_up,
  output logic step_down,
  output logic busy
);

  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = '1;

  logic [1:0] btn_raw;
  logic [1:0] db_vec;
  logic       u_db;
  logic       d_db;

  assign btn_raw = {down_btn, up_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_c(reset_c),
      .btn    (btn_raw[gi]),
      .stable (db_vec[gi])
    );
  end

  assign u_db = db_vec[0];
  assign d_db = db_vec[1];

  state_t           state_reg;
  state_t           state_next;
  dir_t             dir_reg;
  dir_t             dir_next;
  logic             first_reg;
  logic             first_next;
  logic [CNT_W-1:0] timer_reg;
  logic [CNT_W-1:0] timer_next;
  logic             step_up_reg;
  logic             step_up_next;
  logic             step_down_reg;
  logic             step_down_next;
  logic             latched_db;
  logic             opposite_db;
  logic [CNT_W-1:0] wait_last;

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    first_next  = first_reg;
    latched_db  = (dir_reg == DIR_UP) ? u_db : d_db;
    opposite_db = (dir_reg == DIR_UP) ? d_db : u_db;
    wait_last   = (state_reg == WAIT_DLY) ? DLY_LAST : PER_LAST;

    case (state_reg)
      // The timer guard keeps at least PULSE_W low cycles before a fresh press fires,
      // even when the other button was already accepted while the last pulse ran.
      IDLE: begin
        if (u_db && d_db) begin
          state_next = LOCK;
        end else if ((u_db ^ d_db) && !hold_c && (timer_reg >= PW_LAST)) begin
          state_next = FIRE;
          dir_next   = u_db ? DIR_UP : DIR_DOWN;
          first_next = 1'b1;
        end
      end
      FIRE: begin
        if (timer_reg >= PW_LAST) begin
          state_next = first_reg ? WAIT_DLY : WAIT_PER;
        end
      end
      WAIT_DLY, WAIT_PER: begin
        if (!latched_db) begin
          state_next = IDLE;
        end else if (opposite_db) begin
          state_next = LOCK;
        end else if ((timer_reg >= wait_last) && !hold_c) begin
          state_next = FIRE;
          first_next = 1'b0;
        end
      end
      LOCK: begin
        if (!u_db && !d_db) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state_reg) begin
      timer_next = '0;
    end else if (timer_reg == TMR_MAX) begin
      timer_next = timer_reg;
    end else begin
      timer_next = timer_reg + CNT_W'(1);
    end

    step_up_next   = (state_next == FIRE) && (dir_next == DIR_UP);
    step_down_next = (state_next == FIRE) && (dir_next == DIR_DOWN);
  end

  always_ff @(posedge clk or posedge reset_c) begin
    if (reset_c) begin
      state_reg     <= IDLE;
      dir_reg       <= DIR_UP;
      first_reg     <= 1'b0;
      timer_reg     <= '0;
      step_up_reg   <= 1'b0;
      step_down_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      first_reg     <= first_next;
      timer_reg     <= timer_next;
      step_up_reg   <= step_up_next;
      step_down_reg <= step_down_next;
    end
  end

  assign step_up   = step_up_reg;
  assign step_down = step_down_reg;
  assign busy      = (state_reg != IDLE);

endmodule
